// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divide unit: FSM state encodings and
// default operand/tag widths.
package div_unit_pkg;

    localparam int DIV_WIDTH_DEFAULT = 8;
    localparam int DIV_TAG_W_DEFAULT = 4;

    localparam logic [1:0] DIV_IDLE = 2'd0;
    localparam logic [1:0] DIV_BUSY = 2'd1;
    localparam logic [1:0] DIV_DONE = 2'd2;

endpackage

// File: rtl/add_sub.sv
// Combinational adder/subtractor. Vectors are [0:WIDTH-1] with bit 0 as MSB.
// In subtract mode co=1 means no borrow (a >= b).
module add_sub #(
    parameter int WIDTH = 9
) (
    input  logic [0:WIDTH-1] a,
    input  logic [0:WIDTH-1] b,
    input  logic             add_b_sub,
    output logic [0:WIDTH-1] s,
    output logic             co
);

    logic [0:WIDTH-1] b_eff;

    // Two's-complement subtract: a + ~b + 1
    assign b_eff   = add_b_sub ? ~b : b;
    assign {co, s} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, add_b_sub};

endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring unsigned divider for the Tomasulo datapath. Accepts one
// op from its reservation station, iterates WIDTH steps, then holds a tagged CDB result.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT,
    parameter int TAG_W = DIV_TAG_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             flush,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [0:TAG_W-1] issue_tag,
    input  logic [0:WIDTH-1] issue_a,
    input  logic [0:WIDTH-1] issue_b,
    input  logic             issue_rem_sel,
    output logic             cdb_req,
    input  logic             cdb_grant,
    output logic [0:TAG_W-1] cdb_tag,
    output logic [0:WIDTH-1] cdb_data
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

    logic [1:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [0:WIDTH-1] rem_reg, rem_next;
    logic [0:WIDTH-1] quo_reg, quo_next;
    logic [0:WIDTH-1] b_reg, b_next;
    logic [0:TAG_W-1] tag_reg, tag_next;
    logic             rem_sel_reg, rem_sel_next;

    logic [0:WIDTH]   trial_a, trial_b, trial_s;
    logic             trial_co;
    logic [0:WIDTH-1] rem_step, quo_step;

    // Shifted partial remainder needs WIDTH+1 bits: rem can exceed 2^(WIDTH-1) before the shift
    assign trial_a = {rem_reg, quo_reg[0]};
    assign trial_b = {1'b0, b_reg};

    add_sub #(.WIDTH(WIDTH + 1)) u_trial_sub (
        .a         (trial_a),
        .b         (trial_b),
        .add_b_sub (1'b1),
        .s         (trial_s),
        .co        (trial_co)
    );

    assign rem_step = trial_co ? trial_s[1:WIDTH] : trial_a[1:WIDTH];
    assign quo_step = {quo_reg[1:WIDTH-1], trial_co};

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        rem_next     = rem_reg;
        quo_next     = quo_reg;
        b_next       = b_reg;
        tag_next     = tag_reg;
        rem_sel_next = rem_sel_reg;
        case (state_reg)
            DIV_IDLE: begin
                if (issue_valid) begin
                    state_next   = DIV_BUSY;
                    cnt_next     = '0;
                    rem_next     = '0;
                    quo_next     = issue_a;
                    b_next       = issue_b;
                    tag_next     = issue_tag;
                    rem_sel_next = issue_rem_sel;
                end
            end
            DIV_BUSY: begin
                if (cnt_reg == CNT_LAST) begin
                    state_next = DIV_DONE;
                end else begin
                    rem_next = rem_step;
                    quo_next = quo_step;
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            DIV_DONE: begin
                if (cdb_grant) begin
                    state_next = DIV_IDLE;
                end
            end
            default: state_next = DIV_IDLE;
        endcase
        // Squash beats both a same-cycle issue and a same-cycle grant
        if (flush) begin
            state_next = DIV_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_reg   <= DIV_IDLE;
            cnt_reg     <= '0;
            rem_reg     <= '0;
            quo_reg     <= '0;
            b_reg       <= '0;
            tag_reg     <= '0;
            rem_sel_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            rem_reg     <= rem_next;
            quo_reg     <= quo_next;
            b_reg       <= b_next;
            tag_reg     <= tag_next;
            rem_sel_reg <= rem_sel_next;
        end
    end

    assign issue_ready = (state_reg == DIV_IDLE);
    assign cdb_req     = (state_reg == DIV_DONE);
    assign cdb_tag     = cdb_req ? tag_reg : '0;
    assign cdb_data    = cdb_req ? (rem_sel_reg ? rem_reg : quo_reg) : '0;

endmodule
